// File: rtl/eh2_ghr_ckpt_hash.sv
// Branch-predictor GHR tracker with per-lookup checkpoints and PC-fold BHT/BTB hashing; RV_BHT_GHR_HASH_EN mixes GHR into the index.
// One-cycle registered outputs; o_pc_ready drops when every checkpoint slot is live, and flush takes priority over update and lookup.
module eh2_ghr_ckpt_hash #(
   parameter int GHR_SIZE   = 8,
   parameter int IDX_W      = 8,
   parameter int TAG_W      = 9,
   parameter int FOLDS      = 3,
   parameter int CKPT_DEPTH = 4,
   localparam int ID_W      = $clog2(CKPT_DEPTH),
   localparam int CNT_W     = $clog2(CKPT_DEPTH + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_l,
   input  logic                   i_pc_valid,
   output logic                   o_pc_ready,
   input  logic [FOLDS*IDX_W-1:0] i_pc_idx,
   input  logic [FOLDS*TAG_W-1:0] i_pc_tag,
   input  logic                   i_upd_valid,
   input  logic                   i_upd_taken,
   input  logic                   i_ret_valid,
   input  logic                   i_flush_valid,
   input  logic [ID_W-1:0]        i_flush_id,
   input  logic                   i_flush_taken,
   output logic                   o_out_valid,
   output logic [IDX_W-1:0]       o_bht_index,
   output logic [TAG_W-1:0]       o_btb_tag,
   output logic [ID_W-1:0]        o_ckpt_id,
   output logic [GHR_SIZE-1:0]    o_ghr
);

   logic [GHR_SIZE-1:0] r_ghr;
   logic [GHR_SIZE-1:0] r_ckpt [CKPT_DEPTH];
   logic [ID_W-1:0]     r_wr_ptr;
   logic [ID_W-1:0]     r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic                r_out_valid;
   logic [IDX_W-1:0]    r_bht_index;
   logic [TAG_W-1:0]    r_btb_tag;
   logic [ID_W-1:0]     r_ckpt_id;

   logic [IDX_W-1:0]    w_idx_f;
   logic [TAG_W-1:0]    w_tag_f;
   logic [IDX_W-1:0]    w_hash_idx;
   logic                w_accept;
   logic                w_ret;
   logic [ID_W-1:0]     w_rd_ptr_nxt;
   logic [ID_W-1:0]     w_flush_diff;
   logic [CNT_W-1:0]    w_flush_cnt;
   logic [GHR_SIZE-1:0] w_flush_ghr;
   logic [GHR_SIZE-1:0] w_upd_ghr;
   logic [ID_W-1:0]     w_live_off;

   always_comb begin
      w_idx_f = '0;
      w_tag_f = '0;
      for (int k = 0; k < FOLDS; k++) begin
         w_idx_f = w_idx_f ^ i_pc_idx[k*IDX_W +: IDX_W];
         w_tag_f = w_tag_f ^ i_pc_tag[k*TAG_W +: TAG_W];
      end
   end

`ifdef RV_BHT_GHR_HASH_EN
   assign w_hash_idx = w_idx_f ^ IDX_W'(r_ghr);
`else
   assign w_hash_idx = w_idx_f;
`endif

   assign o_pc_ready   = (r_count < CNT_W'(CKPT_DEPTH));
   assign w_accept     = i_pc_valid & o_pc_ready & ~i_flush_valid;
   assign w_ret        = i_ret_valid & (r_count != '0);
   assign w_rd_ptr_nxt = r_rd_ptr + ID_W'(w_ret);

   // Survivors run from the post-retire oldest entry up to and including the flushed one; a zero wrap means the ring is full.
   assign w_flush_diff = i_flush_id - w_rd_ptr_nxt + ID_W'(1);
   assign w_flush_cnt  = (w_flush_diff == '0) ? CNT_W'(CKPT_DEPTH) : CNT_W'(w_flush_diff);
   assign w_flush_ghr  = {r_ckpt[i_flush_id][GHR_SIZE-2:0], i_flush_taken};
   assign w_upd_ghr    = {r_ghr[GHR_SIZE-2:0], i_upd_taken};

   always_ff @(posedge i_clk) begin
      if (!i_rst_l) begin
         r_ghr       <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_bht_index <= '0;
         r_btb_tag   <= '0;
         r_ckpt_id   <= '0;
      end else begin
         r_out_valid <= w_accept;
         if (w_accept) begin
            r_bht_index <= w_hash_idx;
            r_btb_tag   <= w_tag_f;
            r_ckpt_id   <= r_wr_ptr;
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         if (i_flush_valid) begin
            r_ghr    <= w_flush_ghr;
            r_wr_ptr <= i_flush_id + ID_W'(1);
            r_count  <= w_flush_cnt;
         end else begin
            if (i_upd_valid) r_ghr <= w_upd_ghr;
            if (w_accept) r_wr_ptr <= r_wr_ptr + ID_W'(1);
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_ret);
         end
      end
   end

   // Checkpoint storage holds the pre-update history and is deliberately left unreset.
   always_ff @(posedge i_clk) begin
      if (i_rst_l && w_accept) r_ckpt[r_wr_ptr] <= r_ghr;
   end

   assign w_live_off = i_flush_id - r_rd_ptr;

   always_ff @(posedge i_clk) begin
      if (i_rst_l && i_flush_valid) assert (CNT_W'(w_live_off) < r_count);
   end

   assign o_out_valid = r_out_valid;
   assign o_bht_index = r_bht_index;
   assign o_btb_tag   = r_btb_tag;
   assign o_ckpt_id   = r_ckpt_id;
   assign o_ghr       = r_ghr;

endmodule

// File: tb/tb_eh2_ghr_ckpt_hash.sv
// Directed and randomized checks of eh2_ghr_ckpt_hash against a queue-based reference model.
module tb_eh2_ghr_ckpt_hash;

`ifdef RV_BHT_GHR_HASH_EN
   localparam bit HASH_EN = 1'b1;
`else
   localparam bit HASH_EN = 1'b0;
`endif
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        pc_valid, pc_ready;
   logic [23:0] pc_idx;
   logic [26:0] pc_tag;
   logic        upd_valid, upd_taken, ret_valid, flush_valid, flush_taken;
   logic [1:0]  flush_id;
   logic        out_valid;
   logic [7:0]  bht_index;
   logic [8:0]  btb_tag;
   logic [1:0]  ckpt_id;
   logic [7:0]  ghr;

   eh2_ghr_ckpt_hash dut (
      .i_clk(clk), .i_rst_l(rst_l), .i_pc_valid(pc_valid), .o_pc_ready(pc_ready),
      .i_pc_idx(pc_idx), .i_pc_tag(pc_tag), .i_upd_valid(upd_valid), .i_upd_taken(upd_taken),
      .i_ret_valid(ret_valid), .i_flush_valid(flush_valid), .i_flush_id(flush_id),
      .i_flush_taken(flush_taken), .o_out_valid(out_valid), .o_bht_index(bht_index),
      .o_btb_tag(btb_tag), .o_ckpt_id(ckpt_id), .o_ghr(ghr)
   );

   always #5 clk = ~clk;

   typedef struct {int id; int g;} ent_t;
   ent_t q[$];
   int m_ghr, m_wr, m_ovld, m_idx, m_tag, m_id;
   int n_chk = 0, n_pass = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int fold(logic [31:0] v, int w);
      int r = 0;
      for (int k = 0; k < 3; k++) r = r ^ int'((v >> (k * w)) & ((32'd1 << w) - 1));
      return r;
   endfunction

   task automatic model_step();
      bit acc, ret;
      int g0;
      if (!rst_l) begin
         m_ghr = 0; m_wr = 0; m_ovld = 0; m_idx = 0; m_tag = 0; m_id = 0;
         q.delete();
         return;
      end
      acc = pc_valid && (q.size() < D) && !flush_valid;
      ret = ret_valid && (q.size() > 0);
      g0 = m_ghr;
      m_ovld = acc;
      if (acc) begin
         m_idx = fold(32'(pc_idx), 8) ^ (HASH_EN ? g0 : 0);
         m_tag = fold(32'(pc_tag), 9);
         m_id  = m_wr;
      end
      if (ret) void'(q.pop_front());
      if (flush_valid) begin
         while (q.size() > 0 && q[$].id != int'(flush_id)) void'(q.pop_back());
         if (q.size() > 0) m_ghr = ((q[$].g << 1) | int'(flush_taken)) & 'hFF;
         m_wr = (int'(flush_id) + 1) % D;
      end else begin
         if (acc) begin
            q.push_back('{m_wr, g0});
            m_wr = (m_wr + 1) % D;
         end
         if (upd_valid) m_ghr = ((g0 << 1) | int'(upd_taken)) & 'hFF;
      end
   endtask

   task automatic idle();
      pc_valid = 0; pc_idx = '0; pc_tag = '0; upd_valid = 0; upd_taken = 0;
      ret_valid = 0; flush_valid = 0; flush_id = '0; flush_taken = 0;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_ovld));
      chk("bht_index", 32'(bht_index), 32'(m_idx));
      chk("btb_tag", 32'(btb_tag), 32'(m_tag));
      chk("ckpt_id", 32'(ckpt_id), 32'(m_id));
      chk("ghr", 32'(ghr), 32'(m_ghr));
      chk("pc_ready", 32'(pc_ready), 32'(q.size() < D));
      idle();
   endtask

   task automatic do_reset();
      rst_l = 0; step(); rst_l = 1;
   endtask
   task automatic look(logic [23:0] idx, logic [26:0] tag);
      pc_valid = 1; pc_idx = idx; pc_tag = tag; step();
   endtask
   task automatic upd(bit t);
      upd_valid = 1; upd_taken = t; step();
   endtask
   task automatic flush(logic [1:0] id, bit t);
      flush_valid = 1; flush_id = id; flush_taken = t; step();
   endtask

   initial begin
      idle();
      rst_l = 0;
      do_reset();
      chk("rst_ready", 32'(pc_ready), 32'd1);
      chk("rst_ghr", 32'(ghr), 32'd0);

      // hash example
      upd(1); upd(1); upd(0);
      chk("hash_ghr", 32'(ghr), 32'h06);
      look(24'h563412, {9'h00F, 9'h0F0, 9'h1FF});
      chk("hash_vld", 32'(out_valid), 32'd1);
      chk("hash_idx", 32'(bht_index), HASH_EN ? 32'h76 : 32'h70);
      chk("hash_tag", 32'(btb_tag), 32'h100);
      chk("hash_id", 32'(ckpt_id), 32'd0);

      // full and wrap
      do_reset();
      for (int i = 0; i < 4; i++) begin
         look(24'(i), 27'(i));
         chk("full_id", 32'(ckpt_id), 32'(i));
      end
      chk("full_rdy", 32'(pc_ready), 32'd0);
      look(24'h111111, 27'h0);
      chk("full_drop", 32'(out_valid), 32'd0);
      ret_valid = 1; step();
      chk("ret_rdy", 32'(pc_ready), 32'd1);
      look(24'h0, 27'h0);
      chk("wrap_id", 32'(ckpt_id), 32'd0);

      // flush restore
      do_reset();
      upd(1); upd(1); upd(0);
      look(24'h0, 27'h0);
      upd(1); upd(1);
      chk("rest_ghr_pre", 32'(ghr), 32'h1B);
      look(24'h0, 27'h0); look(24'h0, 27'h0);
      flush(2'd0, 1'b0);
      chk("rest_ghr", 32'(ghr), 32'h0C);
      look(24'h0, 27'h0);
      chk("rest_id", 32'(ckpt_id), 32'd1);

      // lookup + update + flush, then retire + flush
      do_reset();
      look(24'h0, 27'h0); look(24'h0, 27'h0);
      pc_valid = 1; upd_valid = 1; upd_taken = 0; flush(2'd0, 1'b1);
      chk("sim_ghr", 32'(ghr), 32'h01);
      chk("sim_vld", 32'(out_valid), 32'd0);
      look(24'h0, 27'h0);
      chk("sim_id", 32'(ckpt_id), 32'd1);
      look(24'h0, 27'h0);
      ret_valid = 1; flush(2'd2, 1'b0);
      look(24'h0, 27'h0);
      chk("rf_rdy1", 32'(pc_ready), 32'd1);
      look(24'h0, 27'h0);
      chk("rf_rdy0", 32'(pc_ready), 32'd0);

      // same-cycle update
      do_reset();
      upd(1);
      pc_valid = 1; upd_valid = 1; upd_taken = 1; step();
      chk("scu_idx", 32'(bht_index), HASH_EN ? 32'h01 : 32'h00);
      chk("scu_ghr", 32'(ghr), 32'h03);

      // reset mid-operation
      do_reset();
      for (int i = 7; i >= 0; i--) upd(bit'((8'hA5 >> i) & 1));
      look(24'h123456, 27'h1); look(24'h0, 27'h2); look(24'h0, 27'h3);
      chk("mid_ghr", 32'(ghr), 32'hA5);
      do_reset();
      chk("mid_rdy", 32'(pc_ready), 32'd1);
      chk("mid_vld", 32'(out_valid), 32'd0);
      chk("mid_idx", 32'(bht_index), 32'd0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int start;
         rst_l = ($urandom_range(0, 255) != 0);
         pc_valid = ($urandom_range(0, 1) == 1);
         pc_idx = 24'($urandom);
         pc_tag = 27'($urandom);
         upd_valid = ($urandom_range(0, 9) < 4);
         upd_taken = 1'($urandom);
         ret_valid = ($urandom_range(0, 9) < 3);
         start = (ret_valid && q.size() > 0) ? 1 : 0;
         if ($urandom_range(0, 99) < 8 && q.size() > start) begin
            flush_valid = 1;
            flush_id = 2'(q[$urandom_range(start, q.size() - 1)].id);
            flush_taken = 1'($urandom);
         end
         step();
      end
      rst_l = 1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
